// File: rtl/sprite_motion_ctrl.sv
// Sprite movement controller: tick-paced moves, jump/fall physics and edge clamping,
// with every position change committed only while the draw engine is idle.
module sprite_motion_ctrl #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCR_W    = 160,
  parameter int SCR_H    = 120,
  parameter int SPR_W    = 10,
  parameter int SPR_H    = 11,
  parameter int START_X  = 0,
  parameter int START_Y  = 109,
  parameter int STEP     = 1,
  parameter int JUMP_H   = 9,
  parameter int TICK_DIV = 3124999,
  parameter int GRAVITY  = 1
) (
  input  logic           CLOCK,
  input  logic           ResetN,
  input  logic [2:0]     cmd,
  input  logic           blocked_u,
  input  logic           blocked_d,
  input  logic           blocked_l,
  input  logic           blocked_r,
  input  logic           draw_busy,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           pos_valid,
  output logic           jumping,
  output logic           falling,
  output logic           tick
);

  localparam int DIV_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int JC_W  = (JUMP_H > 0) ? $clog2(JUMP_H + 1) : 1;

  localparam logic [X_W:0]  MAX_X    = (X_W + 1)'(SCR_W - SPR_W);
  localparam logic [X_W:0]  STEP_X   = (X_W + 1)'(STEP);
  localparam logic [Y_W:0]  FLOOR_Y  = (Y_W + 1)'(SCR_H - SPR_H);
  localparam logic [Y_W:0]  STEP_Y   = (Y_W + 1)'(STEP);
  localparam logic [JC_W:0] JUMP_LIM = (JC_W + 1)'(JUMP_H);

  localparam logic [2:0] CMD_UP    = 3'b001;
  localparam logic [2:0] CMD_RIGHT = 3'b010;
  localparam logic [2:0] CMD_LEFT  = 3'b011;
  localparam logic [2:0] CMD_JUMP  = 3'b100;
  localparam logic [2:0] CMD_DOWN  = 3'b101;

  typedef enum logic [1:0] {IDLE, JUMP_UP, FALL, COMMIT} state_t;

  state_t          state_q, state_d, ret_q, ret_d, mv_ret;
  logic [DIV_W-1:0] div_q, div_d;
  logic            tick_q, tick_d;
  logic [JC_W-1:0] jcnt_q, jcnt_d;
  logic [JC_W:0]   jcnt_inc;
  logic [X_W-1:0]  pos_x_q, pos_x_d, next_x_q, next_x_d, mv_x;
  logic [Y_W-1:0]  pos_y_q, pos_y_d, next_y_q, next_y_d, mv_y;
  logic            pos_valid_q, pos_valid_d;
  logic            jumping_q, jumping_d, falling_q, falling_d;
  logic            mv_go;

  // Positions are widened by one bit so the step can never wrap before clamping.
  function automatic logic [X_W-1:0] move_x(input logic [2:0] c, input logic bl,
                                            input logic br, input logic [X_W-1:0] x);
    logic [X_W:0] w;
    w = {1'b0, x};
    if (c == CMD_RIGHT && !br)
      w = ((w + STEP_X) > MAX_X) ? MAX_X : w + STEP_X;
    else if (c == CMD_LEFT && !bl)
      w = (w >= STEP_X) ? w - STEP_X : '0;
    return w[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] rise_y(input logic [Y_W-1:0] y);
    logic [Y_W:0] w;
    w = {1'b0, y};
    w = (w >= STEP_Y) ? w - STEP_Y : '0;
    return w[Y_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] sink_y(input logic [Y_W-1:0] y);
    logic [Y_W:0] w;
    w = {1'b0, y};
    w = ((w + STEP_Y) > FLOOR_Y) ? FLOOR_Y : w + STEP_Y;
    return w[Y_W-1:0];
  endfunction

  always_comb begin
    div_d       = (div_q == '0) ? DIV_W'(TICK_DIV) : div_q - 1'b1;
    tick_d      = (div_d == '0);
    state_d     = state_q;
    ret_d       = ret_q;
    jcnt_d      = jcnt_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    next_x_d    = next_x_q;
    next_y_d    = next_y_q;
    pos_valid_d = 1'b0;
    jcnt_inc    = {1'b0, jcnt_q} + 1'b1;
    mv_x        = move_x(cmd, blocked_l, blocked_r, pos_x_q);
    mv_y        = pos_y_q;
    mv_ret      = IDLE;
    mv_go       = 1'b0;

    case (state_q)
      IDLE: if (tick_q) begin
        if (GRAVITY != 0 && !blocked_d && ({1'b0, pos_y_q} < FLOOR_Y)) begin
          state_d = FALL;
        end else if (cmd == CMD_JUMP && blocked_d && !blocked_u) begin
          state_d = JUMP_UP;
          jcnt_d  = '0;
        end else begin
          if (GRAVITY == 0 && cmd == CMD_UP && !blocked_u)
            mv_y = rise_y(pos_y_q);
          else if (GRAVITY == 0 && cmd == CMD_DOWN && !blocked_d)
            mv_y = sink_y(pos_y_q);
          mv_ret = IDLE;
          mv_go  = 1'b1;
        end
      end
      JUMP_UP: if (tick_q) begin
        mv_go = 1'b1;
        if (blocked_u) begin
          mv_ret = FALL;
        end else begin
          mv_y   = rise_y(pos_y_q);
          jcnt_d = jcnt_inc[JC_W-1:0];
          mv_ret = (jcnt_inc >= JUMP_LIM || mv_y == '0) ? FALL : JUMP_UP;
        end
      end
      FALL: if (tick_q) begin
        mv_go = 1'b1;
        if (blocked_d || ({1'b0, pos_y_q} >= FLOOR_Y)) begin
          mv_ret = IDLE;
        end else begin
          mv_y   = sink_y(pos_y_q);
          mv_ret = FALL;
        end
      end
      COMMIT: if (!draw_busy) begin
        pos_x_d     = next_x_q;
        pos_y_d     = next_y_q;
        pos_valid_d = 1'b1;
        state_d     = ret_q;
      end
      default: state_d = IDLE;
    endcase

    // A move that changes nothing skips COMMIT and goes straight to its follow-on state.
    if (mv_go) begin
      if (mv_x != pos_x_q || mv_y != pos_y_q) begin
        state_d  = COMMIT;
        next_x_d = mv_x;
        next_y_d = mv_y;
        ret_d    = mv_ret;
      end else begin
        state_d = mv_ret;
      end
    end

    jumping_d = (state_d == JUMP_UP) || (state_d == COMMIT && ret_d == JUMP_UP);
    falling_d = (state_d == FALL) || (state_d == COMMIT && ret_d == FALL);
  end

  always_ff @(posedge CLOCK) begin
    if (!ResetN) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      div_q       <= DIV_W'(TICK_DIV);
      tick_q      <= 1'b0;
      jcnt_q      <= '0;
      pos_x_q     <= X_W'(START_X);
      pos_y_q     <= Y_W'(START_Y);
      next_x_q    <= X_W'(START_X);
      next_y_q    <= Y_W'(START_Y);
      pos_valid_q <= 1'b0;
      jumping_q   <= 1'b0;
      falling_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      jcnt_q      <= jcnt_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      next_x_q    <= next_x_d;
      next_y_q    <= next_y_d;
      pos_valid_q <= pos_valid_d;
      jumping_q   <= jumping_d;
      falling_q   <= falling_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign pos_valid = pos_valid_q;
  assign jumping   = jumping_q;
  assign falling   = falling_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboarded bench for sprite_motion_ctrl: every expected committed position is queued
// when its stimulus is applied and checked when pos_valid pulses.
module tb_sprite_motion_ctrl;

  localparam int TICK_DIV = 3;
  localparam int FLOOR    = 109;
  localparam int MAX_X    = 150;

  logic       CLOCK = 1'b0;
  logic       ResetN = 1'b0;
  logic [2:0] cmd = 3'b000;
  logic       blocked_u = 1'b0, blocked_d = 1'b1, blocked_l = 1'b0, blocked_r = 1'b0;
  logic       draw_busy = 1'b0;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       pos_valid, jumping, falling, tick;

  typedef struct {
    int x;
    int y;
  } pos_t;

  pos_t expQ[$];
  int   total = 0;
  int   bad = 0;

  sprite_motion_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .CLOCK(CLOCK), .ResetN(ResetN), .cmd(cmd),
    .blocked_u(blocked_u), .blocked_d(blocked_d),
    .blocked_l(blocked_l), .blocked_r(blocked_r),
    .draw_busy(draw_busy),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
    .jumping(jumping), .falling(falling), .tick(tick)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] c, input logic bu, input logic bd,
                               input logic bl, input logic br, input logic busy);
    cmd       = c;
    blocked_u = bu;
    blocked_d = bd;
    blocked_l = bl;
    blocked_r = br;
    draw_busy = busy;
  endtask

  task automatic pushPos(input int x, input int y);
    pos_t p;
    p.x = x;
    p.y = y;
    expQ.push_back(p);
  endtask

  task automatic cyc();
    @(negedge CLOCK);
    #1;
  endtask

  task automatic waitTick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < 20);
    if (tick !== 1'b1) checkOutput("tick_timeout", tick, 1);
  endtask

  task automatic waitQueue(input int target, input int budget);
    int n;
    n = 0;
    while (expQ.size() > target && n < budget) begin
      cyc();
      n++;
    end
    if (expQ.size() > target) checkOutput("queue_timeout", expQ.size(), target);
  endtask

  // Every pos_valid pulse must correspond to exactly one queued expectation.
  always @(negedge CLOCK) begin
    pos_t e;
    if (pos_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_pos_valid", pos_valid, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pos_x", pos_x, e.x);
        checkOutput("pos_y", pos_y, e.y);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    $display("[TB] start");
    applyStimulus(3'b000, 0, 1, 0, 0, 0);
    ResetN = 1'b0;
    repeat (3) cyc();
    checkOutput("rst_pos_x", pos_x, 0);
    checkOutput("rst_pos_y", pos_y, FLOOR);
    checkOutput("rst_pos_valid", pos_valid, 0);
    checkOutput("rst_jumping", jumping, 0);
    checkOutput("rst_falling", falling, 0);
    checkOutput("rst_tick", tick, 0);
    ResetN = 1'b1;

    // Walk right to the screen edge.
    applyStimulus(3'b010, 0, 1, 0, 0, 0);
    for (int x = 1; x <= MAX_X; x++) pushPos(x, FLOOR);
    for (int k = 0; k < 2; k++) begin
      waitTick();
      n = 0;
      do begin
        cyc();
        n++;
      end while (tick !== 1'b1 && n < 20);
      checkOutput("tick_period", n, TICK_DIV + 1);
    end
    waitQueue(0, 800);
    checkOutput("x_at_max", pos_x, MAX_X);
    repeat (40) cyc();
    checkOutput("x_hold_max", pos_x, MAX_X);

    // Walk left to 0, hold at the edge, then step to 5 and try left while blocked.
    applyStimulus(3'b011, 0, 1, 0, 0, 0);
    for (int x = MAX_X - 1; x >= 0; x--) pushPos(x, FLOOR);
    waitQueue(0, 800);
    repeat (40) cyc();
    checkOutput("x_hold_zero", pos_x, 0);
    applyStimulus(3'b010, 0, 1, 0, 0, 0);
    for (int x = 1; x <= 5; x++) pushPos(x, FLOOR);
    waitQueue(0, 100);
    applyStimulus(3'b011, 0, 1, 1, 0, 0);
    repeat (40) cyc();
    checkOutput("x_blocked_left", pos_x, 5);
    applyStimulus(3'b000, 0, 1, 0, 0, 0);

    // Full jump: nine rising ticks, then fall back to the floor.
    waitTick();
    applyStimulus(3'b100, 0, 1, 0, 0, 0);
    cyc();
    applyStimulus(3'b000, 0, 0, 0, 0, 0);
    for (int y = FLOOR - 1; y >= FLOOR - 9; y--) pushPos(5, y);
    for (int y = FLOOR - 8; y <= FLOOR; y++) pushPos(5, y);
    waitQueue(17, 40);
    checkOutput("jump_jumping", jumping, 1);
    checkOutput("jump_not_falling", falling, 0);
    waitQueue(9, 60);
    checkOutput("apex_y", pos_y, FLOOR - 9);
    checkOutput("apex_falling", falling, 1);
    checkOutput("apex_not_jumping", jumping, 0);
    waitQueue(0, 60);
    repeat (12) cyc();
    checkOutput("land_y", pos_y, FLOOR);
    checkOutput("land_falling", falling, 0);
    checkOutput("land_jumping", jumping, 0);

    // Head bump at y=104 ends the rise immediately.
    applyStimulus(3'b000, 0, 1, 0, 0, 0);
    waitTick();
    applyStimulus(3'b100, 0, 1, 0, 0, 0);
    cyc();
    applyStimulus(3'b000, 0, 0, 0, 0, 0);
    for (int y = FLOOR - 1; y >= FLOOR - 5; y--) pushPos(5, y);
    for (int y = FLOOR - 4; y <= FLOOR; y++) pushPos(5, y);
    waitQueue(5, 40);
    applyStimulus(3'b000, 1, 0, 0, 0, 0);
    waitTick();
    cyc();
    checkOutput("bump_falling", falling, 1);
    checkOutput("bump_not_jumping", jumping, 0);
    checkOutput("bump_y", pos_y, FLOOR - 5);
    applyStimulus(3'b000, 0, 0, 0, 0, 0);
    waitQueue(0, 60);
    repeat (12) cyc();
    checkOutput("bump_land_y", pos_y, FLOOR);
    checkOutput("bump_land_falling", falling, 0);

    // Draw engine busy across ticks: one commit after release, dropped ticks not replayed.
    applyStimulus(3'b000, 0, 1, 0, 0, 0);
    waitTick();
    applyStimulus(3'b010, 0, 1, 0, 0, 1);
    repeat (10) cyc();
    checkOutput("busy_x_held", pos_x, 5);
    pushPos(6, FLOOR);
    applyStimulus(3'b000, 0, 1, 0, 0, 0);
    cyc();
    checkOutput("busy_release_valid", pos_valid, 1);
    checkOutput("busy_release_x", pos_x, 6);
    cyc();
    checkOutput("busy_single_pulse", pos_valid, 0);
    repeat (20) cyc();
    checkOutput("busy_no_replay", pos_x, 6);

    // Move to x=40, jump to y=103 and reset mid-flight.
    applyStimulus(3'b010, 0, 1, 0, 0, 0);
    for (int x = 7; x <= 40; x++) pushPos(x, FLOOR);
    waitQueue(0, 200);
    applyStimulus(3'b000, 0, 1, 0, 0, 0);
    waitTick();
    applyStimulus(3'b100, 0, 1, 0, 0, 0);
    cyc();
    applyStimulus(3'b000, 0, 0, 0, 0, 0);
    for (int y = FLOOR - 1; y >= FLOOR - 6; y--) pushPos(40, y);
    waitQueue(0, 60);
    checkOutput("mid_jump_y", pos_y, FLOOR - 6);
    checkOutput("mid_jump_jumping", jumping, 1);
    ResetN = 1'b0;
    applyStimulus(3'b000, 0, 1, 0, 0, 0);
    cyc();
    ResetN = 1'b1;
    checkOutput("rst2_pos_x", pos_x, 0);
    checkOutput("rst2_pos_y", pos_y, FLOOR);
    checkOutput("rst2_jumping", jumping, 0);
    checkOutput("rst2_falling", falling, 0);
    checkOutput("rst2_pos_valid", pos_valid, 0);
    repeat (40) cyc();
    checkOutput("rst2_hold_x", pos_x, 0);
    checkOutput("rst2_hold_y", pos_y, FLOOR);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
